shift_seq_ctrl: RTL and testbench

//   Sequencer for an external WIDTH-bit bidirectional shift register (clear, shift-right, shift-left, serial in).

---
 rtl/shift_seq_pkg.sv | 16 +
 rtl/shift_seq_bitcnt.sv | 27 ++
 rtl/shift_seq_ctrl.sv | 128 ++++++++++++
 tb/tb_shift_seq_ctrl.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_seq_pkg.sv
// Shared state encoding and sizing helper for the shift-register sequencer.
package shift_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        SHIFT = 3'd2,
        CAPT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_seq_bitcnt.sv
// Loadable down-counter tracking the remaining shift pulses; flags the last bit and empty.
module shift_seq_bitcnt #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             last,
    output logic             zero
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign last = (cnt == CNT_W'(1));
    assign zero = (cnt == '0);

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for an external bidirectional shift register: clear, shift len bits, capture, respond.
// Optional SHIFT_SEQ_PARITY_EN adds rsp_parity, the XOR of the bits driven on sr_din.
module shift_seq_ctrl
    import shift_seq_pkg::*;
#(
    parameter  int WIDTH = 4,
    localparam int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_len,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_clr,
    output logic             sr_clr,
    output logic             sr_shift,
    output logic             sr_right,
    output logic             sr_din,
    input  logic [WIDTH-1:0] sr_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
`ifdef SHIFT_SEQ_PARITY_EN
    output logic             rsp_parity,
`endif
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q;
    logic             dir_q;
    logic [CNT_W-1:0] len_sat;
    logic [CNT_W-1:0] cnt;
    logic             cnt_last, cnt_zero;
    logic             accept;

    assign len_sat = (cmd_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : cmd_len;
    assign accept  = cmd_valid && (state_q == IDLE);

    shift_seq_bitcnt #(.CNT_W(CNT_W)) u_bitcnt (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .load_val (len_sat),
        .dec      (state_q == SHIFT),
        .cnt      (cnt),
        .last     (cnt_last),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_clr)
                        state_d = CLEAR;
                    else if (len_sat != '0)
                        state_d = SHIFT;
                    else
                        state_d = CAPT;
                end
            end
            CLEAR:   state_d = cnt_zero ? CAPT : SHIFT;
            // Leaving on the last-bit cycle yields exactly len pulses.
            SHIFT:   if (cnt_last) state_d = CAPT;
            CAPT:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q <= '0;
            dir_q  <= 1'b0;
        end else if (accept) begin
            data_q <= cmd_data;
            dir_q  <= cmd_dir;
        end else if (state_q == SHIFT) begin
            data_q <= data_q >> 1;
        end
    end

    // CAPT follows the final shift edge, so sr_q already holds the finished word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            rsp_data <= '0;
        else if (state_q == CAPT)
            rsp_data <= sr_q;
    end

`ifdef SHIFT_SEQ_PARITY_EN
    logic par_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q      <= 1'b0;
            rsp_parity <= 1'b0;
        end else begin
            if (accept)
                par_q <= 1'b0;
            else if (state_q == SHIFT)
                par_q <= par_q ^ data_q[0];
            if (state_q == CAPT)
                rsp_parity <= par_q;
        end
    end
`endif

    assign cmd_ready = rst && (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign sr_clr    = (state_q == CLEAR);
    assign sr_shift  = (state_q == SHIFT);
    assign sr_right  = sr_shift && dir_q;
    assign sr_din    = sr_shift && data_q[0];
    assign rsp_valid = (state_q == RESP);

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural shift register and a response scoreboard.
module tb_shift_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_dir = 1'b0;
    logic [CNT_W-1:0] cmd_len = '0;
    logic [WIDTH-1:0] cmd_data = '0;
    logic             cmd_clr = 1'b0;
    logic             sr_clr, sr_shift, sr_right, sr_din;
    logic [WIDTH-1:0] sr_q = '0;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_data;
`ifdef SHIFT_SEQ_PARITY_EN
    logic             rsp_parity;
`endif
    logic             busy;

    logic             sr_load = 1'b0;
    logic [WIDTH-1:0] sr_load_val = '0;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             par;
    } rsp_t;
    rsp_t exp_q[$];

    int tests = 0;
    int fails = 0;
    int npulse = 0, nclr = 0, dir_bad = 0, idle_bad = 0;
    logic [WIDTH-1:0] din_seq = '0;
    logic exp_dir = 1'b0;

    always #5 clk = ~clk;

    shift_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_len   (cmd_len),
        .cmd_data  (cmd_data),
        .cmd_clr   (cmd_clr),
        .sr_clr    (sr_clr),
        .sr_shift  (sr_shift),
        .sr_right  (sr_right),
        .sr_din    (sr_din),
        .sr_q      (sr_q),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
`ifdef SHIFT_SEQ_PARITY_EN
        .rsp_parity(rsp_parity),
`endif
        .busy      (busy)
    );

    always @(posedge clk) begin
        if (sr_load)
            sr_q <= sr_load_val;
        else if (sr_clr)
            sr_q <= '0;
        else if (sr_shift)
            sr_q <= sr_right ? {sr_din, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], sr_din};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: pops on every response handshake.
    always @(negedge clk) begin
        rsp_t e;
        if (rst && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("rsp_data", 32'(rsp_data), 32'(e.data));
`ifdef SHIFT_SEQ_PARITY_EN
                chk("rsp_parity", 32'(rsp_parity), 32'(e.par));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (sr_shift) begin
            if (npulse < WIDTH) din_seq[npulse] = sr_din;
            if (sr_right !== exp_dir) dir_bad++;
            npulse++;
        end else if (sr_right || sr_din) begin
            idle_bad++;
        end
        if (sr_clr) nclr++;
    end

    task automatic preload(input logic [WIDTH-1:0] v);
        @(posedge clk); #1;
        sr_load = 1'b1; sr_load_val = v;
        @(posedge clk); #1;
        sr_load = 1'b0;
    endtask

    task automatic run_cmd(input string name, input logic clr, input logic dir,
                           input logic [CNT_W-1:0] len, input logic [WIDTH-1:0] data,
                           input logic [WIDTH-1:0] exp_data, input logic exp_par,
                           input int exp_lat, input int exp_pulses, input int hold);
        int lat, guard;
        logic [WIDTH-1:0] mask;
        rsp_t e;
        e.data = exp_data; e.par = exp_par;
        exp_q.push_back(e);
        mask = (exp_pulses >= WIDTH) ? '1 : WIDTH'((1 << exp_pulses) - 1);
        @(posedge clk); #1;
        cmd_clr = clr; cmd_dir = dir; cmd_len = len; cmd_data = data; cmd_valid = 1'b1;
        exp_dir = dir;
        guard = 0;
        while (!cmd_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        chk({name, "_accept_wait"}, 32'(guard < 50), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        npulse = 0; nclr = 0; dir_bad = 0; idle_bad = 0; din_seq = '0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1; cmd_clr = 1'b1; cmd_len = 3'd4;
            @(posedge clk); #1;
            chk({name, "_hold"}, {rsp_valid, busy, cmd_ready, rsp_data},
                {1'b1, 1'b1, 1'b0, exp_data});
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({name, "_after_hs"}, {busy, cmd_ready, rsp_valid}, 3'b010);
        chk({name, "_pulses"}, 32'(npulse), 32'(exp_pulses));
        chk({name, "_clr_pulses"}, 32'(nclr), 32'(clr));
        chk({name, "_din_seq"}, 32'(din_seq), 32'(data & mask));
        chk({name, "_dir_idle"}, 32'(dir_bad + idle_bad), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {cmd_ready, busy, sr_clr, sr_shift, sr_right, sr_din, rsp_valid, rsp_data},
            '0);
        @(negedge clk); rst = 1'b1;
        #1;
        chk("post_reset", {cmd_ready, busy, rsp_data}, {1'b1, 1'b0, 4'h0});

        preload(4'hF);
        run_cmd("t1", 1'b1, 1'b1, 3'd4, 4'b1011, 4'b1011, 1'b1, 6, 4, 0);
        run_cmd("t2", 1'b1, 1'b0, 3'd4, 4'b1011, 4'b1101, 1'b1, 6, 4, 0);
        preload(4'b0011);
        run_cmd("t3", 1'b0, 1'b0, 3'd2, 4'b1110, 4'b1101, 1'b1, 3, 2, 0);
        preload(4'b1010);
        run_cmd("t4_len0", 1'b0, 1'b1, 3'd0, 4'b1111, 4'b1010, 1'b0, 1, 0, 0);
        run_cmd("t4_len7", 1'b1, 1'b1, 3'd7, 4'b0110, 4'b0110, 1'b0, 6, 4, 0);
        preload(4'b0000);
        run_cmd("t5_hold", 1'b0, 1'b1, 3'd1, 4'b0001, 4'b1000, 1'b1, 2, 1, 5);

        // Abort during the second SHIFT cycle.
        @(posedge clk); #1;
        cmd_clr = 1'b0; cmd_dir = 1'b1; cmd_len = 3'd4; cmd_data = 4'b1111; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #2;
        chk("t6_in_shift", {busy, sr_shift}, 2'b11);
        rst = 1'b0;
        #1;
        chk("t6_async_reset", {cmd_ready, busy, sr_clr, sr_shift, sr_right, sr_din, rsp_valid, rsp_data},
            '0);
        @(negedge clk); rst = 1'b1;
        #1;
        chk("t6_release", {cmd_ready, busy}, 2'b10);
        run_cmd("t6_after", 1'b1, 1'b0, 3'd3, 4'b0101, 4'b0101, 1'b0, 5, 3, 0);

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
